// File: rtl/ram4k_bist_pkg.sv
// Shared state encodings and default widths for the ram4k BIST initiator.
package ram4k_bist_pkg;

  localparam int unsigned RAM_ADDR_W = 12;
  localparam int unsigned RAM_DATA_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ram4k_bist_if.sv
// ram4k memory-side bus: the BIST is the master, the memory is the slave.
interface ram4k_bist_if
  import ram4k_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
);

  logic [DATA_W-1:0] mem_in;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  modport master (output mem_in, output mem_address, output mem_load, input mem_out);
  modport slave  (input mem_in, input mem_address, input mem_load, output mem_out);

endinterface

// File: rtl/ram_bist_agen.sv
// Window index plus latched base/seed; produces the word address and expected pattern.
module ram_bist_agen
  import ram4k_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              latch,
  input  logic              step,
  input  logic              clr,
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] expected
);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;

  always_comb begin
    idx_d  = idx_q;
    base_d = base_q;
    seed_d = seed_q;
    if (latch) begin
      idx_d  = '0;
      base_d = base;
      seed_d = seed;
    end else if (clr) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q  <= '0;
      base_q <= '0;
      seed_q <= '0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
      seed_q <= seed_d;
    end
  end

  // Both sums truncate, so the window wraps at the top of the array.
  assign idx      = idx_q;
  assign addr     = base_q + idx_q;
  assign expected = seed_q + DATA_W'(idx_q);

endmodule

// File: rtl/ram4k_bist.sv
// Write/read-back self-test of a ram4k window: FSM, compare and result registers.
module ram4k_bist
  import ram4k_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] seed,
  ram4k_bist_if.master      mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic              pass_q, pass_d;

  logic              accept, step, clr, last, mismatch, active;
  logic [ADDR_W:0]   count_clamped;
  logic [ADDR_W-1:0] idx, addr;
  logic [DATA_W-1:0] expected;

  ram_bist_agen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_agen (
    .clk      (clk),
    .reset_n  (reset_n),
    .latch    (accept),
    .step     (step),
    .clr      (clr),
    .base     (base),
    .seed     (seed),
    .idx      (idx),
    .addr     (addr),
    .expected (expected)
  );

  assign accept        = (state_q == ST_IDLE) && start;
  assign count_clamped = (count > MaxCount) ? MaxCount : count;
  // count_q is at least 1 whenever this is used (WRITE/READ only).
  assign last          = ({1'b0, idx} == (count_q - 1'b1));
  assign mismatch      = (state_q == ST_READ) && (mem.mem_out != expected);

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    pass_d           = pass_q;
    step             = 1'b0;
    clr              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d          = count_clamped;
          err_count_d      = '0;
          first_err_addr_d = '0;
          if (count_clamped == '0) begin
            pass_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            pass_d  = 1'b0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (last) begin
          clr     = 1'b1;
          state_d = ST_READ;
        end else begin
          step = 1'b1;
        end
      end
      ST_READ: begin
        if (mismatch) begin
          err_count_d = err_count_q + 1'b1;
          if (err_count_q == '0) first_err_addr_d = addr;
        end
        // pass is settled on entry to DONE so it is valid alongside the done pulse.
        if (last) begin
          pass_d  = !mismatch && (err_count_q == '0);
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      count_q          <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      pass_q           <= pass_d;
    end
  end

  assign active          = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign busy            = active;
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_addr  = first_err_addr_q;

  assign mem.mem_address = active ? addr : '0;
  assign mem.mem_in      = (state_q == ST_WRITE) ? expected : '0;
  // Gated by reset_n so a reset edge can never commit a write.
  assign mem.mem_load    = (state_q == ST_WRITE) && reset_n;

endmodule
